div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Initiator-side controller for the handshaked 32-bit signed divider in the M-extension execute path.
- Accepts DIV requests from the execute stage and resolves the RISC-V special cases locally (divide by zero, signed overflow).
- Drives the divider's input handshake, consumes its output handshake, and returns a held result with its own valid/ready handshake.
- Owns flush handling: the divider cannot abort, so an in-flight operation is drained and its result discarded.

Parameters:
- DATA_W, 32, operand/result width (fixed by divider; only 32 supported).
- TIMEOUT_CYCLES, 64, watchdog limit for the WAIT state (used only with DIV_TIMEOUT_EN).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset; one clock, no other clock domains.
- req_valid_i  in  1  execute stage presents a DIV request.
- req_ready_o  out  1  controller can accept a request; high only in IDLE.
- req_a_i  in  32  dividend, signed.
- req_b_i  in  32  divisor, signed.
- flush_i  in  1  pipeline flush; abandons the current operation.
- resp_valid_o  out  1  result available.
- resp_ready_i  in  1  execute stage accepts the result.
- resp_data_o  out  32  quotient, signed.
- div_a_o  out  32  divider dividend.
- div_b_o  out  32  divider divisor.
- div_in_valid_o  out  1  operands valid to divider.
- div_in_ready_i  in  1  divider accepts operands.
- div_out_valid_i  in  1  divider result valid.
- div_out_ready_o  out  1  controller accepts divider result.
- div_c_i  in  32  divider quotient; defined only while div_out_valid_i && div_out_ready_o.
- timeout_o  out  1  sticky watchdog error; exists only with DIV_TIMEOUT_EN.

Behaviour:
- Transfer on any channel = valid && ready sampled at a rising edge.
- Reset values:
  - req_ready_o = 0 in the reset cycle, then 1 in IDLE.
  - resp_valid_o = 0, resp_data_o = 0.
  - div_in_valid_o = 0, div_out_ready_o = 0.
  - div_a_o = 0, div_b_o = 0, timeout_o = 0.
  - Reset aborts any state, including mid-WAIT. The divider is reset by the same system reset, so there is no drain after reset.
- FSM states: IDLE, ISSUE, WAIT, DRAIN, RESP.
- IDLE:
  - req_ready_o = 1.
  - On request transfer, register operands into div_a_o/div_b_o.
  - req_b_i == 0: set resp_data_o = 32'hFFFFFFFF and go to RESP (divider untouched).
  - req_a_i == 32'h80000000 && req_b_i == 32'hFFFFFFFF: set resp_data_o = 32'h80000000 and go to RESP.
  - Otherwise go to ISSUE.
  - Special-case bypass latency: resp_valid_o is high the cycle after acceptance.
- ISSUE:
  - div_in_valid_o = 1.
  - div_a_o/div_b_o are held stable until transfer.
  - On div_in_ready_i, go to WAIT.
- WAIT:
  - div_out_ready_o = 1.
  - On div_out_valid_i, capture div_c_i into resp_data_o in that same cycle and go to RESP.
- RESP:
  - resp_valid_o = 1; resp_data_o is stable until transfer.
  - On resp_ready_i, go to IDLE.
  - A new request cannot be accepted in the same cycle as the response transfer: req_ready_o is 0 in RESP.
- Flush (has priority over every other transition):
  - IDLE: any request presented in the same cycle is not accepted.
  - ISSUE, no transfer this cycle: drop div_in_valid_o and go to IDLE. This is legal because the divider commits only on transfer.
  - ISSUE, transfer this cycle: go to DRAIN.
  - WAIT: go to DRAIN.
  - RESP: drop the response and go to IDLE.
- DRAIN:
  - div_out_ready_o = 1.
  - On div_out_valid_i, discard the result and go to IDLE.
  - flush_i has no further effect here.
- Outputs are registered, except req_ready_o, div_in_valid_o, div_out_ready_o and resp_valid_o, which are decoded directly from the state register.
- Normal (non-bypass) latency = 2 + divider latency + 1 cycles from request acceptance to resp_valid_o.

Optional Feature:
- Macro: DIV_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to WAIT/DRAIN and increments every cycle there.
  - When it reaches TIMEOUT_CYCLES: set timeout_o (sticky until reset), return resp_data_o = 32'hFFFFFFFF through RESP, and go to IDLE.
  - This applies from WAIT; from DRAIN the controller goes to IDLE silently.
  - A late divider result is then accepted in IDLE and discarded: div_out_ready_o is 1 in IDLE.
- Undefined:
  - No counter and no timeout_o port.
  - WAIT/DRAIN wait indefinitely.
  - div_out_ready_o is 0 in IDLE.

Test Plan:
- 100 / 7 -> resp_data_o = 14, exactly one divider input transfer; -100 / 7 -> 32'hFFFFFFF2.
- 5 / 0 -> resp_data_o = 32'hFFFFFFFF one cycle after accept; div_in_valid_o never asserted.
- 32'h80000000 / 32'hFFFFFFFF -> 32'h80000000 via bypass, divider idle.
- Divider holds div_in_ready_i low for 4 cycles -> div_in_valid_o stays high with div_a_o/div_b_o stable; 42 / 6 -> 7.
- flush_i in WAIT of 1000 / 3 -> no resp_valid_o, DRAIN consumes the divider result; next request 42 / 6 -> 7, not 333.
- resp_ready_i low 3 cycles -> resp_valid_o and resp_data_o held; req_ready_o = 0 throughout. With DIV_TIMEOUT_EN and a stalled divider: timeout_o = 1 after 64 WAIT cycles, resp_data_o = 32'hFFFFFFFF.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// div_issue_ctrl
// ---------------------------------------------------------------------------
// Initiator-side controller for the handshaked 32-bit signed divider used by
// the M-extension execute path. It accepts DIV requests, resolves the RISC-V
// special cases (divide by zero, signed overflow) locally, drives the
// divider's operand handshake, collects the quotient and presents it on a
// held response handshake. The divider cannot abort, so a flushed operation
// that the divider already owns is drained and its result thrown away.
//
// Handshakes: every channel transfers on a rising edge where valid && ready
// are both high. A valid is never withdrawn before its transfer, except when
// flush_i abandons the operation (div_in_valid_o in ISSUE, resp_valid_o in
// RESP).
//
// Optional feature (macro DIV_TIMEOUT_EN): watchdog on WAIT/DRAIN. After
// TIMEOUT_CYCLES cycles in WAIT the controller answers 32'hFFFFFFFF and sets
// the sticky timeout_o; in DRAIN it silently returns to IDLE. A late divider
// result is then absorbed in IDLE (div_out_ready_o is high there).
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   req_valid_i/ready_o   request handshake; req_a_i / req_b_i signed operands
//   flush_i               abandon the current operation
//   resp_valid_o/ready_i  response handshake; resp_data_o signed quotient
//   div_a_o/div_b_o       divider operands, div_in_valid_o/div_in_ready_i
//   div_out_valid_i       divider result handshake with div_out_ready_o,
//   div_c_i               divider quotient
//   timeout_o             sticky watchdog error (DIV_TIMEOUT_EN only)
//   state_dbg_o           current FSM state for observation
// ---------------------------------------------------------------------------
module div_issue_ctrl #(
   parameter int DATA_W = 32
`ifdef DIV_TIMEOUT_EN
   ,
   parameter int TIMEOUT_CYCLES = 64
`endif
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [DATA_W-1:0] req_a_i,
   input  logic [DATA_W-1:0] req_b_i,
   input  logic              flush_i,
   output logic              resp_valid_o,
   input  logic              resp_ready_i,
   output logic [DATA_W-1:0] resp_data_o,
   output logic [DATA_W-1:0] div_a_o,
   output logic [DATA_W-1:0] div_b_o,
   output logic              div_in_valid_o,
   input  logic              div_in_ready_i,
   input  logic              div_out_valid_i,
   output logic              div_out_ready_o,
   input  logic [DATA_W-1:0] div_c_i,
`ifdef DIV_TIMEOUT_EN
   output logic              timeout_o,
`endif
   output logic [2:0]        state_dbg_o
);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_ISSUE = 3'd1,
      ST_WAIT  = 3'd2,
      ST_DRAIN = 3'd3,
      ST_RESP  = 3'd4
   } state_e;

   localparam logic [DATA_W-1:0] ALL_ONES = '1;
   localparam logic [DATA_W-1:0] INT_MIN  = {1'b1, {(DATA_W-1){1'b0}}};

   state_e            state_q, state_d;
   logic [DATA_W-1:0] a_q, a_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic [DATA_W-1:0] data_q, data_d;

`ifdef DIV_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             tmo_hit;
   // Last cycle of the budget: the counter starts at zero on the first
   // WAIT/DRAIN cycle, so TIMEOUT_CYCLES-1 marks cycle number TIMEOUT_CYCLES.
   assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

   // ------------------------------------------------------------------------
   // Next-state and datapath
   // ------------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      data_d  = data_q;
`ifdef DIV_TIMEOUT_EN
      cnt_d     = cnt_q;
      timeout_d = timeout_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            // A request presented together with a flush belongs to the
            // flushed instruction stream and is dropped.
            if (req_valid_i && !flush_i) begin
               a_d = req_a_i;
               b_d = req_b_i;
               if (req_b_i == '0) begin
                  data_d  = ALL_ONES;
                  state_d = ST_RESP;
               end else if (req_a_i == INT_MIN && req_b_i == ALL_ONES) begin
                  data_d  = INT_MIN;
                  state_d = ST_RESP;
               end else begin
                  state_d = ST_ISSUE;
               end
            end
         end

         ST_ISSUE: begin
`ifdef DIV_TIMEOUT_EN
            cnt_d = '0;
`endif
            if (flush_i) begin
               // Once the divider has taken the operands it will produce a
               // result that must be consumed.
               state_d = div_in_ready_i ? ST_DRAIN : ST_IDLE;
            end else if (div_in_ready_i) begin
               state_d = ST_WAIT;
            end
         end

         ST_WAIT: begin
`ifdef DIV_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
`endif
            if (flush_i) begin
               // A result arriving in the flush cycle is consumed right here,
               // so nothing is left to drain.
               state_d = div_out_valid_i ? ST_IDLE : ST_DRAIN;
`ifdef DIV_TIMEOUT_EN
               cnt_d = '0;
`endif
            end else if (div_out_valid_i) begin
               data_d  = div_c_i;
               state_d = ST_RESP;
`ifdef DIV_TIMEOUT_EN
            end else if (tmo_hit) begin
               timeout_d = 1'b1;
               data_d    = ALL_ONES;
               state_d   = ST_RESP;
`endif
            end
         end

         ST_DRAIN: begin
`ifdef DIV_TIMEOUT_EN
            cnt_d = cnt_q + CNT_W'(1);
            if (div_out_valid_i || tmo_hit) begin
               state_d = ST_IDLE;
            end
`else
            if (div_out_valid_i) begin
               state_d = ST_IDLE;
            end
`endif
         end

         ST_RESP: begin
            if (flush_i || resp_ready_i) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // ------------------------------------------------------------------------
   // State and registered outputs
   // ------------------------------------------------------------------------
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         data_q  <= '0;
`ifdef DIV_TIMEOUT_EN
         cnt_q     <= '0;
         timeout_q <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         data_q  <= data_d;
`ifdef DIV_TIMEOUT_EN
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
`endif
      end
   end

   // ------------------------------------------------------------------------
   // State-decoded handshake outputs. Ready outputs are masked while reset is
   // asserted so nothing is accepted before the state register is defined.
   // ------------------------------------------------------------------------
   assign req_ready_o    = (state_q == ST_IDLE) && !reset;
   assign div_in_valid_o = (state_q == ST_ISSUE);
   assign resp_valid_o   = (state_q == ST_RESP);
`ifdef DIV_TIMEOUT_EN
   // IDLE also absorbs a result that arrives after a watchdog expiry.
   assign div_out_ready_o = (state_q == ST_WAIT) || (state_q == ST_DRAIN) ||
                            ((state_q == ST_IDLE) && !reset);
   assign timeout_o       = timeout_q;
`else
   assign div_out_ready_o = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
`endif

   assign div_a_o     = a_q;
   assign div_b_o     = b_q;
   assign resp_data_o = data_q;
   assign state_dbg_o = state_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed cases with literal results, then a
// randomized phase. A transaction-level model (outstanding request, queue of
// expected quotients) is compared against the DUT outputs every cycle.
module tb_div_issue_ctrl;

  // clock / reset ------------------------------------------------------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic        req_valid_i, req_ready_o, flush_i;
  logic [31:0] req_a_i, req_b_i;
  logic        resp_valid_o, resp_ready_i;
  logic [31:0] resp_data_o;
  logic [31:0] div_a_o, div_b_o, div_c_i;
  logic        div_in_valid_o, div_in_ready_i, div_out_valid_i, div_out_ready_o;
  logic [2:0]  state_dbg_o;
`ifdef DIV_TIMEOUT_EN
  logic        timeout_o;
`endif

  div_issue_ctrl dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_a_i(req_a_i), .req_b_i(req_b_i), .flush_i(flush_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_data_o(resp_data_o),
    .div_a_o(div_a_o), .div_b_o(div_b_o),
    .div_in_valid_o(div_in_valid_o), .div_in_ready_i(div_in_ready_i),
    .div_out_valid_i(div_out_valid_i), .div_out_ready_o(div_out_ready_o),
    .div_c_i(div_c_i),
`ifdef DIV_TIMEOUT_EN
    .timeout_o(timeout_o),
`endif
    .state_dbg_o(state_dbg_o)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    chk(nm, {31'b0, act}, {31'b0, exp});
  endtask

  // RISC-V DIV semantics
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    int sa, sb;
    if (b == 32'd0) return 32'hFFFF_FFFF;
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
    sa = int'(a);
    sb = int'(b);
    return 32'(sa / sb);
  endfunction

  // transaction model ---------------------------------------------------------
  logic [31:0] exp_q[$];
  bit          m_out, m_avail, m_issued, m_held, m_drain;
  logic [31:0] m_a, m_b, last_resp;
  int          n_issue, n_resp, n_out;
  bit          ev_in, ev_out;
  logic [31:0] ev_a, ev_b;
`ifdef DIV_TIMEOUT_EN
  int m_wcnt, m_dcnt;
  bit m_tmo;
`endif

  // divider model controls
  bit          dv_rand = 1'b0;
  bit          dv_hold = 1'b0;
  int          dv_lat_fix = 3;
  int          dv_stall = 0;

  // scoreboard / compare process: outputs and inputs are stable here
  always @(negedge clock) begin
    bit fl, acc, ix, ox, rx, exp_dor;
    if (reset) begin
      exp_q.delete();
      m_out = 0; m_avail = 0; m_issued = 0; m_held = 0; m_drain = 0;
      ev_in = 0; ev_out = 0;
`ifdef DIV_TIMEOUT_EN
      m_wcnt = 0; m_dcnt = 0; m_tmo = 0;
`endif
    end else begin
      // output checks
      chk1("req_ready", req_ready_o, !m_out && !m_drain);
      chk1("div_in_valid", div_in_valid_o, m_out && !m_avail && !m_issued);
      if (div_in_valid_o && m_out) begin
        chk("div_a", div_a_o, m_a);
        chk("div_b", div_b_o, m_b);
      end
`ifdef DIV_TIMEOUT_EN
      exp_dor = (m_held && !(m_out && m_avail)) || (!m_out && !m_drain);
      chk1("timeout", timeout_o, m_tmo);
`else
      exp_dor = m_held;
`endif
      chk1("div_out_ready", div_out_ready_o, exp_dor);
      chk1("resp_valid", resp_valid_o, m_out && m_avail);
      if (resp_valid_o && exp_q.size() > 0) chk("resp_data", resp_data_o, exp_q[0]);

      // events at the coming rising edge
      fl  = flush_i;
      acc = req_valid_i && req_ready_o && !fl;
      ix  = div_in_valid_o && div_in_ready_i;
      ox  = div_out_valid_i && div_out_ready_o;
      rx  = resp_valid_o && resp_ready_i;
      ev_in = ix; ev_out = ox; ev_a = div_a_o; ev_b = div_b_o;

`ifdef DIV_TIMEOUT_EN
      if (m_out && m_held && !m_avail && !fl && !ox) begin
        m_wcnt++;
        if (m_wcnt == 64) begin
          m_avail = 1; exp_q[0] = 32'hFFFF_FFFF; m_tmo = 1;
        end
      end
      if (m_drain && !ox) begin
        m_dcnt++;
        if (m_dcnt == 64) m_drain = 0;
      end
`endif
      if (ix) begin
        n_issue++;
        if (m_issued) chk1("single_issue", 1'b1, 1'b0);
        m_issued = 1; m_held = 1;
`ifdef DIV_TIMEOUT_EN
        m_wcnt = 0;
`endif
      end
      if (ox) begin
        n_out++;
        m_held = 0; m_drain = 0;
        if (m_out && m_issued && !m_avail && !fl) m_avail = 1;
      end
      if (fl) begin
        if (m_out) begin
          void'(exp_q.pop_front());
          m_out = 0; m_drain = m_held;
`ifdef DIV_TIMEOUT_EN
          m_dcnt = 0;
`endif
        end
      end else if (rx) begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        last_resp = resp_data_o;
        n_resp++;
        m_out = 0;
      end
      if (acc) begin
        m_out = 1; m_issued = 0;
        m_a = req_a_i; m_b = req_b_i;
        exp_q.push_back(ref_div(req_a_i, req_b_i));
        m_avail = (req_b_i == 32'd0) || (req_a_i == 32'h8000_0000 && req_b_i == 32'hFFFF_FFFF);
      end
    end
  end

  // divider responder: one operation at a time, configurable latency/stalls
  initial begin
    bit          dv_busy;
    int          dv_lat;
    logic [31:0] dv_res;
    dv_busy = 0; dv_lat = 0; dv_res = '0;
    div_in_ready_i = 0; div_out_valid_i = 0; div_c_i = '0;
    forever begin
      @(posedge clock); #1;
      if (reset) begin
        dv_busy = 0; div_out_valid_i = 0; div_in_ready_i = 0;
      end else begin
        if (ev_out) begin dv_busy = 0; div_out_valid_i = 0; end
        if (ev_in) begin
          dv_busy = 1;
          dv_res  = ref_div(ev_a, ev_b);
          dv_lat  = dv_rand ? int'($urandom_range(0, 6)) : dv_lat_fix;
        end
        if (dv_busy && !div_out_valid_i) begin
          if (dv_lat == 0 && !dv_hold) begin
            div_out_valid_i = 1; div_c_i = dv_res;
          end else if (dv_lat > 0) dv_lat--;
        end
        if (!div_out_valid_i) div_c_i = $urandom;
        if (dv_busy) div_in_ready_i = 0;
        else if (dv_stall > 0 && div_in_valid_o) begin div_in_ready_i = 0; dv_stall--; end
        else div_in_ready_i = dv_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // driver tasks --------------------------------------------------------------
  task automatic do_req(input logic [31:0] a, input logic [31:0] b, input int rdelay,
                        input logic [31:0] exp_v, input int exp_iss, input bit bypass,
                        input string nm);
    int iss0, wait_i;
    bit got;
    logic [31:0] held;
    iss0 = n_issue;
    @(posedge clock); #1;
    req_valid_i = 1; req_a_i = a; req_b_i = b;
    got = 0;
    for (int i = 0; i < 200 && !got; i++) begin @(negedge clock); got = req_ready_o; end
    chk1({nm, "_accepted"}, got, 1'b1);
    @(posedge clock); #1;
    req_valid_i = 0;
    got = 0; wait_i = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clock); got = resp_valid_o; wait_i = i;
    end
    chk1({nm, "_resp_seen"}, got, 1'b1);
    if (bypass) chk({nm, "_bypass_latency"}, wait_i, 0);
    held = resp_data_o;
    for (int i = 0; i < rdelay; i++) begin
      @(negedge clock);
      chk1({nm, "_held_valid"}, resp_valid_o, 1'b1);
      chk({nm, "_held_data"}, resp_data_o, held);
      chk1({nm, "_held_req_ready"}, req_ready_o, 1'b0);
    end
    @(posedge clock); #1;
    resp_ready_i = 1;
    @(posedge clock); #1;
    resp_ready_i = 0;
    chk({nm, "_result"}, last_resp, exp_v);
    chk({nm, "_issues"}, n_issue - iss0, exp_iss);
  endtask

  // stimulus ------------------------------------------------------------------
  initial begin
    int out0, resp0, iss0;
    bit got;
    reset = 1; req_valid_i = 0; req_a_i = '0; req_b_i = '0; flush_i = 0; resp_ready_i = 0;
    @(posedge clock);
    @(negedge clock);
    chk1("rst_req_ready", req_ready_o, 1'b0);
    chk1("rst_resp_valid", resp_valid_o, 1'b0);
    chk("rst_resp_data", resp_data_o, 32'd0);
    chk1("rst_div_in_valid", div_in_valid_o, 1'b0);
    chk1("rst_div_out_ready", div_out_ready_o, 1'b0);
    chk("rst_div_a", div_a_o, 32'd0);
    chk("rst_div_b", div_b_o, 32'd0);
`ifdef DIV_TIMEOUT_EN
    chk1("rst_timeout", timeout_o, 1'b0);
`endif
    @(posedge clock); #1;
    reset = 0;

    do_req(32'd100, 32'd7, 0, 32'd14, 1, 0, "div_100_7");
    do_req(-32'sd100, 32'd7, 0, 32'hFFFF_FFF2, 1, 0, "div_m100_7");
    do_req(32'd5, 32'd0, 0, 32'hFFFF_FFFF, 0, 1, "div_by_zero");
    do_req(32'h8000_0000, 32'hFFFF_FFFF, 0, 32'h8000_0000, 0, 1, "overflow");
    dv_stall = 4;
    do_req(32'd42, 32'd6, 0, 32'd7, 1, 0, "in_stall");
    do_req(32'd77, -32'sd7, 3, 32'hFFFF_FFF5, 1, 0, "resp_stall");

    // flush while the divider owns 1000 / 3
    dv_lat_fix = 6;
    out0 = n_out; resp0 = n_resp; iss0 = n_issue;
    @(posedge clock); #1;
    req_valid_i = 1; req_a_i = 32'd1000; req_b_i = 32'd3;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clock); got = req_ready_o; end
    @(posedge clock); #1;
    req_valid_i = 0;
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin @(negedge clock); got = (n_issue != iss0); end
    chk1("flush_issued", got, 1'b1);
    @(posedge clock); #1;
    flush_i = 1;
    @(posedge clock); #1;
    flush_i = 0;
    got = 0;
    for (int i = 0; i < 100 && !got; i++) begin @(negedge clock); got = req_ready_o; end
    chk1("flush_back_idle", got, 1'b1);
    chk("flush_drained", n_out - out0, 1);
    chk("flush_no_resp", n_resp - resp0, 0);
    dv_lat_fix = 3;
    do_req(32'd42, 32'd6, 0, 32'd7, 1, 0, "after_flush");

`ifdef DIV_TIMEOUT_EN
    dv_hold = 1;
    do_req(32'd9, 32'd3, 0, 32'hFFFF_FFFF, 1, 0, "timeout_resp");
    chk1("timeout_sticky", timeout_o, 1'b1);
    out0 = n_out;
    dv_hold = 0;
    got = 0;
    for (int i = 0; i < 20 && !got; i++) begin @(negedge clock); got = (n_out != out0); end
    chk1("late_result_absorbed", got, 1'b1);
    @(posedge clock); #1;
    chk1("timeout_still_set", timeout_o, 1'b1);
`endif

    // randomized phase
    dv_rand = 1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clock); #1;
      req_valid_i = ($urandom_range(0, 1) == 1);
      case ($urandom_range(0, 5))
        0: begin req_a_i = $urandom; req_b_i = 32'd0; end
        1: begin req_a_i = 32'h8000_0000; req_b_i = 32'hFFFF_FFFF; end
        2: begin req_a_i = $urandom_range(0, 1000); req_b_i = $urandom_range(1, 20); end
        3: begin req_a_i = -$urandom_range(0, 1000); req_b_i = $urandom_range(1, 20); end
        default: begin req_a_i = $urandom; req_b_i = $urandom; end
      endcase
      resp_ready_i = ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 24) == 0);
    end
    @(posedge clock); #1;
    req_valid_i = 0; flush_i = 0; resp_ready_i = 1;
    repeat (40) @(posedge clock);
    #1;
    chk("final_queue_empty", exp_q.size(), 0);
    chk("random_progress", (n_resp > 100) ? 32'd1 : 32'd0, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
